// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: shared state type and default sizing for the multi-channel pulse stretcher
package pulse_stretcher_pkg;
  typedef enum logic {IDLE, STRETCH} ps_state_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/pulse_stretcher_ch.sv
// pulse_stretcher_ch: one channel of edge detect, countdown FSM and registered pulse/done outputs
module pulse_stretcher_ch
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             retrig,
  input  logic             in,
  input  logic [CNT_W-1:0] delay_value,
  output logic             pulse_out,
  output logic             done
);
  logic in_d;
  logic [CNT_W-1:0] cnt;
  ps_state_t state;
  logic trig;
  logic dv_ok;
  assign trig = in & ~in_d & en;
  assign dv_ok = |delay_value;
  // a zero delay never leaves IDLE and never reloads, so cnt stays in 1..max while stretching
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_d <= 1'b0;
      cnt <= '0;
      state <= IDLE;
      pulse_out <= 1'b0;
      done <= 1'b0;
    end else begin
      in_d <= in;
      done <= 1'b0;
      if (state == IDLE) begin
        if (trig && dv_ok) begin
          cnt <= delay_value;
          state <= STRETCH;
          pulse_out <= 1'b1;
        end
      end else if (trig && retrig && dv_ok) begin
        cnt <= delay_value;
      end else if (cnt == CNT_W'(1)) begin
        state <= IDLE;
        pulse_out <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pulse_stretcher_mc.sv
// pulse_stretcher_mc: NUM_CH independent pulse stretchers with a shared enable/retrigger mode and busy flag
module pulse_stretcher_mc
  import pulse_stretcher_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              retrig,
  input  logic [NUM_CH-1:0] in,
  input  logic [CNT_W-1:0]  delay_value [NUM_CH],
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] done,
  output logic              busy
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_stretcher_ch #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rstn(rstn),
      .en(en),
      .retrig(retrig),
      .in(in[i]),
      .delay_value(delay_value[i]),
      .pulse_out(pulse_out[i]),
      .done(done[i])
    );
  end
  assign busy = |pulse_out;
endmodule

// File: tb/tb_pulse_stretcher_mc.sv
// tb_pulse_stretcher_mc: table-driven per-cycle vectors plus hand-written reset, basic and max-delay sequences
module tb_pulse_stretcher_mc;
  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic retrig;
  logic [3:0] in;
  logic [7:0] dv [4];
  logic [3:0] pulse_out;
  logic [3:0] done;
  logic busy;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string nm;
    logic en;
    logic rt;
    logic [3:0] in;
    logic [31:0] dv;
    logic [3:0] po;
    logic [3:0] dn;
  } vec_t;

  vec_t tbl[$];

  pulse_stretcher_mc #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .retrig(retrig),
    .in(in),
    .delay_value(dv),
    .pulse_out(pulse_out),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string n, input logic e, input logic r, input logic [3:0] i,
                              input logic [31:0] d, input logic [3:0] p, input logic [3:0] dn);
    vec_t v;
    v.nm = n; v.en = e; v.rt = r; v.in = i; v.dv = d; v.po = p; v.dn = dn;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    int dn_cnt;
    int dn_at;
    // all channels together, delays 1..4, non-retrigger
    tbl.push_back(mk("all4", 1, 0, 4'hF, 32'h04030201, 4'hF, 4'h0));
    tbl.push_back(mk("all4", 1, 0, 4'hF, 32'h04030201, 4'hE, 4'h1));
    tbl.push_back(mk("all4", 1, 0, 4'h0, 32'h04030201, 4'hC, 4'h2));
    tbl.push_back(mk("all4", 1, 0, 4'h0, 32'h04030201, 4'h8, 4'h4));
    tbl.push_back(mk("all4", 1, 0, 4'h0, 32'h04030201, 4'h0, 4'h8));
    tbl.push_back(mk("all4", 1, 0, 4'h0, 32'h04030201, 4'h0, 4'h0));
    // retrigger: ch1 delay 5, edges at 0 and 3 -> 8 contiguous cycles
    tbl.push_back(mk("retrig", 1, 1, 4'h2, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("retrig", 1, 1, 4'h0, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("retrig", 1, 1, 4'h0, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("retrig", 1, 1, 4'h2, 32'h00000500, 4'h2, 4'h0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk("retrig", 1, 1, 4'h0, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("retrig", 1, 1, 4'h0, 32'h00000500, 4'h0, 4'h2));
    tbl.push_back(mk("retrig", 1, 1, 4'h0, 32'h00000500, 4'h0, 4'h0));
    // non-retrigger, same stimulus -> 5 cycles
    tbl.push_back(mk("noretrig", 1, 0, 4'h2, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("noretrig", 1, 0, 4'h0, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("noretrig", 1, 0, 4'h0, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("noretrig", 1, 0, 4'h2, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("noretrig", 1, 0, 4'h0, 32'h00000500, 4'h2, 4'h0));
    tbl.push_back(mk("noretrig", 1, 0, 4'h0, 32'h00000500, 4'h0, 4'h2));
    tbl.push_back(mk("noretrig", 1, 0, 4'h0, 32'h00000500, 4'h0, 4'h0));
    // edge on the cnt==1 cycle, non-retrigger -> ignored
    tbl.push_back(mk("last_nort", 1, 0, 4'h4, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_nort", 1, 0, 4'h0, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_nort", 1, 0, 4'h0, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_nort", 1, 0, 4'h4, 32'h00030000, 4'h0, 4'h4));
    tbl.push_back(mk("last_nort", 1, 0, 4'h0, 32'h00030000, 4'h0, 4'h0));
    // edge on the cnt==1 cycle, retrigger -> seamless extension
    tbl.push_back(mk("last_rt", 1, 1, 4'h4, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_rt", 1, 1, 4'h0, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_rt", 1, 1, 4'h0, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_rt", 1, 1, 4'h4, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_rt", 1, 1, 4'h0, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_rt", 1, 1, 4'h0, 32'h00030000, 4'h4, 4'h0));
    tbl.push_back(mk("last_rt", 1, 1, 4'h0, 32'h00030000, 4'h0, 4'h4));
    tbl.push_back(mk("last_rt", 1, 1, 4'h0, 32'h00030000, 4'h0, 4'h0));
    // en=0 blocks the edge
    tbl.push_back(mk("en_off", 0, 0, 4'h1, 32'h00000004, 4'h0, 4'h0));
    tbl.push_back(mk("en_off", 0, 0, 4'h0, 32'h00000004, 4'h0, 4'h0));
    // en dropped mid-stretch -> completes
    tbl.push_back(mk("en_drop", 1, 0, 4'h1, 32'h00000003, 4'h1, 4'h0));
    tbl.push_back(mk("en_drop", 0, 0, 4'h0, 32'h00000003, 4'h1, 4'h0));
    tbl.push_back(mk("en_drop", 0, 0, 4'h0, 32'h00000003, 4'h1, 4'h0));
    tbl.push_back(mk("en_drop", 0, 0, 4'h0, 32'h00000003, 4'h0, 4'h1));
    tbl.push_back(mk("en_drop", 0, 0, 4'h0, 32'h00000003, 4'h0, 4'h0));
    // zero delay -> dropped
    tbl.push_back(mk("dly0", 1, 0, 4'h8, 32'h00000000, 4'h0, 4'h0));
    tbl.push_back(mk("dly0", 1, 0, 4'h0, 32'h00000000, 4'h0, 4'h0));
    // delay changed mid-stretch -> length unchanged
    tbl.push_back(mk("dly_chg", 1, 0, 4'h1, 32'h00000003, 4'h1, 4'h0));
    tbl.push_back(mk("dly_chg", 1, 0, 4'h0, 32'h0000000A, 4'h1, 4'h0));
    tbl.push_back(mk("dly_chg", 1, 0, 4'h0, 32'h0000000A, 4'h1, 4'h0));
    tbl.push_back(mk("dly_chg", 1, 0, 4'h0, 32'h0000000A, 4'h0, 4'h1));
    tbl.push_back(mk("dly_chg", 1, 0, 4'h0, 32'h0000000A, 4'h0, 4'h0));
    // retrigger with zero delay ignored
    tbl.push_back(mk("rt_dly0", 1, 1, 4'h1, 32'h00000003, 4'h1, 4'h0));
    tbl.push_back(mk("rt_dly0", 1, 1, 4'h0, 32'h00000000, 4'h1, 4'h0));
    tbl.push_back(mk("rt_dly0", 1, 1, 4'h1, 32'h00000000, 4'h1, 4'h0));
    tbl.push_back(mk("rt_dly0", 1, 1, 4'h0, 32'h00000000, 4'h0, 4'h1));
    tbl.push_back(mk("rt_dly0", 1, 1, 4'h0, 32'h00000000, 4'h0, 4'h0));

    rstn = 1'b0; en = 1'b0; retrig = 1'b0; in = 4'h0;
    for (int c = 0; c < 4; c++) dv[c] = 8'd0;
    #20;
    chk("rst_po", 32'(pulse_out), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk) rstn = 1'b1;
    tick();

    // basic: ch0 delay 12, input held 3 cycles
    dv[0] = 8'd12; en = 1'b1; in = 4'h1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) in = 4'h0;
      chk("basic_po", 32'(pulse_out), (k <= 12) ? 32'h1 : 32'h0);
      chk("basic_done", 32'(done), (k == 13) ? 32'h1 : 32'h0);
      chk("basic_busy", 32'(busy), (k <= 12) ? 32'h1 : 32'h0);
    end

    foreach (tbl[n]) begin
      en = tbl[n].en; retrig = tbl[n].rt; in = tbl[n].in;
      for (int c = 0; c < 4; c++) dv[c] = tbl[n].dv[c*8 +: 8];
      tick();
      chk({tbl[n].nm, "_po"}, 32'(pulse_out), 32'(tbl[n].po));
      chk({tbl[n].nm, "_done"}, 32'(done), 32'(tbl[n].dn));
      chk({tbl[n].nm, "_busy"}, 32'(busy), 32'(|tbl[n].po));
    end

    // maximum delay: 255 high cycles, done right after
    en = 1'b1; retrig = 1'b0;
    for (int c = 0; c < 4; c++) dv[c] = 8'd0;
    dv[2] = 8'd255; in = 4'h4;
    hi = 0; dn_cnt = 0; dn_at = 0;
    for (int k = 1; k <= 258; k++) begin
      tick();
      if (k == 1) in = 4'h0;
      if (pulse_out[2]) hi++;
      if (done[2]) begin dn_cnt++; dn_at = k; end
    end
    chk("max_high", 32'(hi), 32'd255);
    chk("max_done_cnt", 32'(dn_cnt), 32'd1);
    chk("max_done_at", 32'(dn_at), 32'd256);

    // reset mid-stretch, input high at release
    dv[0] = 8'd10; in = 4'h1;
    tick();
    in = 4'h0;
    tick();
    tick();
    chk("mid_po_pre", 32'(pulse_out), 32'h1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_po", 32'(pulse_out), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    in = 4'h2; dv[1] = 8'd2;
    tick();
    chk("inrst_po", 32'(pulse_out), 32'h0);
    chk("inrst_done", 32'(done), 32'h0);
    @(negedge clk) rstn = 1'b1;
    tick();
    chk("rel_po1", 32'(pulse_out), 32'h2);
    chk("rel_done1", 32'(done), 32'h0);
    tick();
    chk("rel_po2", 32'(pulse_out), 32'h2);
    chk("rel_done2", 32'(done), 32'h0);
    tick();
    chk("rel_po3", 32'(pulse_out), 32'h0);
    chk("rel_done3", 32'(done), 32'h2);
    in = 4'h0;
    tick();
    chk("rel_idle", 32'({done, pulse_out}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_stretcher_mc.md
Name: pulse_stretcher_mc

Overview:
Multi-channel, parametrised pulse stretcher. It is the next generation of the single-channel, 4-bit-delay stretcher. Each channel detects a rising edge on its input and drives its output high for a programmable number of clock cycles, with a per-channel delay. A global mode selects whether an edge arriving mid-stretch restarts the window (retrigger) or is ignored. The block sits between asynchronous-origin event sources (already synchronised upstream) and downstream logic that needs minimum-width pulses.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
CNT_W, 8, width of delay value and internal counter; max stretch = 2**CNT_W-1 cycles

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  reset, asynchronous and active-low
en  input  1  global trigger enable
retrig  input  1  1 = retrigger mode, 0 = non-retrigger mode (sampled per cycle)
in  input  NUM_CH  event inputs, one bit per channel, synchronous to clk
delay_value  input  NUM_CH x CNT_W (unpacked array [NUM_CH][CNT_W])  stretch length per channel, in cycles
pulse_out  output  NUM_CH  stretched pulses, registered
done  output  NUM_CH  1-cycle pulse in the first cycle after a channel's stretch ends
busy  output  1  OR of all pulse_out bits

Behaviour:
- Reset (rstn=0, async): pulse_out=0, done=0, busy=0, all counters=0, all states IDLE, edge-detect registers in_d=0.
- in_d is always registered from in, regardless of en or state.
- The in_d reset value of 0 means an input already high at reset release counts as an edge.
- Trigger: trig[i] = in[i] & ~in_d[i] & en.
- Per-channel FSM, states IDLE and STRETCH:
  - IDLE, trig, delay_value[i]!=0: load cnt=delay_value[i], go STRETCH.
  - IDLE, trig, delay_value[i]==0: edge dropped; stay IDLE; no done.
  - STRETCH, cnt>1: cnt decrements by 1.
  - STRETCH, cnt==1, no accepted trigger: go IDLE; assert done[i] for the next cycle.
  - STRETCH, trig, retrig=1, delay_value[i]!=0: reload cnt=delay_value[i]; stay STRETCH; no done. This applies on any cycle, including cnt==1, so the output is continuous.
  - STRETCH, trig, retrig=1, delay_value[i]==0: trigger ignored; countdown continues.
  - STRETCH, trig, retrig=0: trigger ignored, including on the cnt==1 cycle.
- pulse_out[i] = registered (state==STRETCH).
- Latency: edge sampled at clock edge n; pulse_out high from n+1 through n+delay inclusive (exactly delay_value cycles); done high at cycle n+delay+1 for one cycle.
- delay_value is latched at trigger. Changes during STRETCH have no effect until the next accepted trigger.
- en=0 blocks new triggers only. In-flight stretches complete and generate done.
- retrig is sampled on the same clock edge as the trigger.
- Channels are fully independent. Simultaneous triggers on all channels are legal.
- Counter never underflows or wraps. Max delay (2**CNT_W-1) yields exactly that many high cycles.
- Reset mid-stretch: outputs drop to 0 immediately (async), no done generated.
- busy is combinational OR of the pulse_out registers (no extra latency).

Decomposition:
- Package pulse_stretcher_pkg holds:
  - typedef enum logic {IDLE, STRETCH} ps_state_t
  - localparam defaults for NUM_CH and CNT_W
- Sub-module pulse_stretcher_ch (parameter CNT_W) implements one channel: edge detect, FSM, counter, pulse_out/done bit.
- The top generates NUM_CH instances and the busy OR.

Test Plan:
- Basic: reset 20ns, release; ch0 delay=12, in[0] rises and holds 3 cycles -> pulse_out[0] high exactly 12 cycles starting 1 cycle after edge; done[0] one cycle after; other channels stay 0.
- Retrigger: retrig=1, ch1 delay=5, edges at cycles 0 and 3 -> pulse_out[1] high 8 contiguous cycles (1..8), single done at cycle 9.
- Non-retrigger: retrig=0, same stimulus -> pulse_out[1] high cycles 1..5 only; edge at 3 ignored; done at 6. Also edge exactly on cnt==1 cycle -> ignored, no extension.
- Boundaries: delay=0 edge -> no pulse, no done. delay=255 (CNT_W=8) -> exactly 255 high cycles. delay_value changed mid-stretch -> length unchanged.
- en and all channels: en=0 edge -> ignored; en dropped mid-stretch -> stretch completes. All 4 channels triggered same cycle with delays 1,2,3,4 -> independent widths; busy high for 4 cycles.
- Reset mid-operation: assert rstn low during STRETCH -> pulse_out/busy go 0 asynchronously, no done; in held high at release -> new stretch starts.
